// File: rtl/regfile_param_if.sv
// Register-file port bundle: two write ports, busy marking, NREAD packed read ports.
// The master side drives writes, busy marks and read addresses; the slave side returns read data and status.
interface regfile_param_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int NREAD = 2
);
   localparam int AW = $clog2(DEPTH);

   logic                   we0;
   logic [AW-1:0]          waddr0;
   logic [WIDTH-1:0]       wdata0;
   logic                   we1;
   logic [AW-1:0]          waddr1;
   logic [WIDTH-1:0]       wdata1;
   logic                   busy_set;
   logic [AW-1:0]          busy_addr;
   logic [NREAD*AW-1:0]    raddr;
   logic [NREAD*WIDTH-1:0] rdata;
   logic [NREAD-1:0]       rbusy;
   logic [AW:0]            busy_count;

   modport master (
      output we0, waddr0, wdata0, we1, waddr1, wdata1, busy_set, busy_addr, raddr,
      input  rdata, rbusy, busy_count
   );

   modport slave (
      input  we0, waddr0, wdata0, we1, waddr1, wdata1, busy_set, busy_addr, raddr,
      output rdata, rbusy, busy_count
   );
endinterface

// File: rtl/regfile_param.sv
// Multi-read, dual-write register file with a pending-load scoreboard; writes land at the rising edge.
// Reads are combinational (zero latency) with optional same-cycle bypass; there is no backpressure.
module regfile_param #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic           clk,
   input  logic           reset,
   regfile_param_if.slave rf
);
   localparam int AW   = $clog2(DEPTH);
   localparam bit FULL = (DEPTH == (1 << AW));

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [AW:0]      cnt;

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return FULL || ({{(32-AW){1'b0}}, a} < 32'(DEPTH));
   endfunction

   function automatic logic is_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   logic wr0_ok, wr1_ok, set_ok, rise, fall;

   assign wr0_ok = rf.we0 && addr_ok(rf.waddr0) && !is_zero(rf.waddr0);
   assign wr1_ok = rf.we1 && addr_ok(rf.waddr1) && !is_zero(rf.waddr1);
   assign set_ok = rf.busy_set && addr_ok(rf.busy_addr) && !is_zero(rf.busy_addr);

   // A retiring load on the same register as a newly issued one leaves it busy, so no fall.
   assign rise = set_ok && !busy[rf.busy_addr];
   assign fall = wr1_ok && busy[rf.waddr1] && !(set_ok && (rf.busy_addr == rf.waddr1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         busy <= '0;
         cnt  <= '0;
      end else begin
         if (wr0_ok) mem[rf.waddr0] <= rf.wdata0;
         if (wr1_ok) mem[rf.waddr1] <= rf.wdata1;
         if (wr1_ok) busy[rf.waddr1] <= 1'b0;
         if (set_ok) busy[rf.busy_addr] <= 1'b1;
         cnt <= cnt + (AW+1)'(rise) - (AW+1)'(fall);
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0]    a;
      logic [WIDTH-1:0] d;
      logic             b;

      assign a = rf.raddr[i*AW +: AW];

      // Port 1 forwarding takes priority, matching its priority on a same-address write.
      always_comb begin
         d = addr_ok(a) ? mem[a] : '0;
         b = addr_ok(a) ? busy[a] : 1'b0;
         if (BYPASS != 0) begin
            if (rf.we1 && (rf.waddr1 == a)) begin
               d = rf.wdata1;
               b = 1'b0;
            end else if (rf.we0 && (rf.waddr0 == a)) begin
               d = rf.wdata0;
            end
         end
         if (is_zero(a)) begin
            d = '0;
            b = 1'b0;
         end
      end

      assign rf.rdata[i*WIDTH +: WIDTH] = d;
      assign rf.rbusy[i]                = b;
   end

   assign rf.busy_count = cnt;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default build (32x32, 2 reads, bypass) and a 16x8, 4-read, no-bypass build.
// Random and directed traffic is checked against an array/popcount reference model.
module tb_regfile_param;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   regfile_param_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) ifa ();
   regfile_param_if #(.WIDTH(16), .DEPTH(8),  .NREAD(4)) ifb ();

   regfile_param #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
      .clk(clk), .reset(reset), .rf(ifa)
   );
   regfile_param #(.WIDTH(16), .DEPTH(8), .NREAD(4), .ZERO_REG(0), .BYPASS(0)) u_b (
      .clk(clk), .reset(reset), .rf(ifb)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // active configuration
   int          phase;
   int          depth, nread, zr, byp;
   logic [31:0] msk;

   // stimulus
   bit          we0, we1, bs;
   int          wa0, wa1, ba;
   logic [31:0] wd0, wd1;
   int          ra [4];

   // reference state
   logic [31:0] mem_m [32];
   bit          busy_m [32];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_rdata(input int a);
      if (zr != 0 && a == 0) return 32'h0;
      if (byp != 0 && we1 && wa1 == a) return wd1 & msk;
      if (byp != 0 && we0 && wa0 == a) return wd0 & msk;
      return mem_m[a];
   endfunction

   function automatic logic exp_rbusy(input int a);
      if (zr != 0 && a == 0) return 1'b0;
      if (byp != 0 && we1 && wa1 == a) return 1'b0;
      return busy_m[a];
   endfunction

   function automatic int exp_count();
      int n = 0;
      for (int k = 0; k < depth; k++) n += int'(busy_m[k]);
      return n;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 32; k++) begin
         mem_m[k]  = 32'h0;
         busy_m[k] = 1'b0;
      end
   endtask

   task automatic model_update();
      if (we0 && !(zr != 0 && wa0 == 0)) mem_m[wa0] = wd0 & msk;
      if (we1 && !(zr != 0 && wa1 == 0)) begin
         mem_m[wa1]  = wd1 & msk;
         busy_m[wa1] = 1'b0;
      end
      if (bs && !(zr != 0 && ba == 0)) busy_m[ba] = 1'b1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; bs = 0;
      wa0 = 0; wa1 = 0; ba = 0;
      wd0 = 0; wd1 = 0;
      for (int k = 0; k < 4; k++) ra[k] = 0;
   endtask

   task automatic drive();
      ifa.we0 = 0; ifa.we1 = 0; ifa.busy_set = 0; ifa.waddr0 = 0; ifa.waddr1 = 0;
      ifa.busy_addr = 0; ifa.wdata0 = 0; ifa.wdata1 = 0; ifa.raddr = 0;
      ifb.we0 = 0; ifb.we1 = 0; ifb.busy_set = 0; ifb.waddr0 = 0; ifb.waddr1 = 0;
      ifb.busy_addr = 0; ifb.wdata0 = 0; ifb.wdata1 = 0; ifb.raddr = 0;
      if (phase == 0) begin
         ifa.we0 = we0; ifa.waddr0 = 5'(wa0); ifa.wdata0 = wd0;
         ifa.we1 = we1; ifa.waddr1 = 5'(wa1); ifa.wdata1 = wd1;
         ifa.busy_set = bs; ifa.busy_addr = 5'(ba);
         ifa.raddr = {5'(ra[1]), 5'(ra[0])};
      end else begin
         ifb.we0 = we0; ifb.waddr0 = 3'(wa0); ifb.wdata0 = 16'(wd0);
         ifb.we1 = we1; ifb.waddr1 = 3'(wa1); ifb.wdata1 = 16'(wd1);
         ifb.busy_set = bs; ifb.busy_addr = 3'(ba);
         ifb.raddr = {3'(ra[3]), 3'(ra[2]), 3'(ra[1]), 3'(ra[0])};
      end
   endtask

   task automatic compare(input string pfx);
      logic [31:0] gd;
      logic        gb;
      logic [31:0] gc;
      for (int i = 0; i < nread; i++) begin
         if (phase == 0) begin
            gd = ifa.rdata[i*32 +: 32];
            gb = ifa.rbusy[i];
         end else begin
            gd = {16'h0, ifb.rdata[i*16 +: 16]};
            gb = ifb.rbusy[i];
         end
         check($sformatf("%s_rdata%0d_a%0d", pfx, i, ra[i]), 64'(gd), 64'(exp_rdata(ra[i])));
         check($sformatf("%s_rbusy%0d_a%0d", pfx, i, ra[i]), 64'(gb), 64'(exp_rbusy(ra[i])));
      end
      gc = (phase == 0) ? 32'(ifa.busy_count) : 32'(ifb.busy_count);
      check($sformatf("%s_count", pfx), 64'(gc), 64'(exp_count()));
   endtask

   // Drive, check combinational outputs mid-cycle, then advance the model across the edge.
   task automatic step(input string pfx);
      drive();
      @(negedge clk);
      compare(pfx);
      @(posedge clk);
      if (!reset) model_update();
      #1;
   endtask

   function automatic int rand_addr();
      if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 3));
      return int'($urandom_range(0, depth - 1));
   endfunction

   task automatic rand_inputs();
      we0 = ($urandom_range(0, 1) == 1);
      we1 = ($urandom_range(0, 2) == 0);
      bs  = ($urandom_range(0, 2) == 0);
      wa0 = rand_addr(); wa1 = rand_addr(); ba = rand_addr();
      wd0 = $urandom & msk; wd1 = $urandom & msk;
      for (int k = 0; k < 4; k++) ra[k] = (k < nread) ? rand_addr() : 0;
   endtask

   task automatic cfg(input int p);
      phase = p;
      if (p == 0) begin
         depth = 32; nread = 2; zr = 1; byp = 1; msk = 32'hFFFF_FFFF;
      end else begin
         depth = 8; nread = 4; zr = 0; byp = 0; msk = 32'h0000_FFFF;
      end
   endtask

   initial begin
      cfg(0);
      model_reset();
      idle();
      step("rst_idle");
      // writes and busy marks while reset is held must not stick
      we0 = 1; wa0 = 4; wd0 = 32'h1234; bs = 1; ba = 4; ra[1] = 4;
      step("rst_hold");
      reset = 1'b0;
      idle(); ra[0] = 4;
      step("rst_after");

      // preload r5 busy, then async reset mid-cycle
      idle(); we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; bs = 1; ba = 5;
      step("preload");
      idle(); ra[0] = 5;
      step("preload_rd");
      reset = 1'b1;
      #1;
      check("async_rst_rdata", 64'(ifa.rdata[31:0]), 64'h0);
      check("async_rst_rbusy", 64'(ifa.rbusy[0]), 64'h0);
      check("async_rst_count", 64'(ifa.busy_count), 64'h0);
      model_reset();
      idle(); ra[0] = 5;
      step("rst_mid");
      reset = 1'b0;

      // dual-write conflict, port 1 wins, forwarded same cycle
      idle(); we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h11; wd1 = 32'h22; ra[0] = 7;
      step("conflict");
      idle(); ra[0] = 7; drive(); #1;
      check("conflict_r7", 64'(ifa.rdata[31:0]), 64'h22);

      // zero register
      idle(); we0 = 1; we1 = 1; wd0 = 32'hFFFF_FFFF; wd1 = 32'hFFFF_FFFF; bs = 1;
      step("zero_wr");
      idle();
      step("zero_rd");

      // scoreboard set then retire via port 1
      idle(); bs = 1; ba = 3;
      step("sb_set");
      idle(); ra[0] = 3; ra[1] = 3; drive(); #1;
      check("sb_rbusy", 64'(ifa.rbusy[0]), 64'h1);
      check("sb_count1", 64'(ifa.busy_count), 64'h1);
      step("sb_busy");
      idle(); we1 = 1; wa1 = 3; wd1 = 32'h55; ra[0] = 3;
      step("sb_retire");
      idle(); ra[0] = 3; drive(); #1;
      check("sb_count0", 64'(ifa.busy_count), 64'h0);

      // set/clear collision on r9
      idle(); bs = 1; ba = 9;
      step("col_set");
      idle(); bs = 1; ba = 9; we1 = 1; wa1 = 9; wd1 = 32'hABC; ra[1] = 9;
      step("col_both");
      idle(); ra[0] = 9; drive(); #1;
      check("col_busy", 64'(ifa.rbusy[0]), 64'h1);
      check("col_count", 64'(ifa.busy_count), 64'h1);
      check("col_data", 64'(ifa.rdata[31:0]), 64'hABC);

      for (int n = 0; n < 300; n++) begin
         rand_inputs();
         step("rand_a");
      end

      // second build: narrower, four read ports, no bypass, r0 ordinary
      reset = 1'b1;
      #1;
      cfg(1);
      model_reset();
      idle();
      step("b_rst");
      reset = 1'b0;
      idle(); we0 = 1; wa0 = 6; wd0 = 32'hBEEF; ra[0] = 6; drive(); #1;
      check("b_nobyp", 64'(ifb.rdata[15:0]), 64'h0);
      step("b_wr6");
      idle(); ra[0] = 6; ra[1] = 1; ra[2] = 6; ra[3] = 0; drive(); #1;
      check("b_r6", 64'(ifb.rdata[15:0]), 64'hBEEF);
      for (int a = 0; a < 8; a++) begin
         idle(); bs = 1; ba = a; ra[0] = a; ra[1] = (a + 1) % 8; ra[2] = (a + 3) % 8; ra[3] = 7 - a;
         step("b_fill");
      end
      idle(); drive(); #1;
      check("b_count_full", 64'(ifb.busy_count), 64'h8);
      for (int n = 0; n < 300; n++) begin
         rand_inputs();
         step("rand_b");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised multi-read, dual-write register file for the MIPS datapath. It is the next generation of the single-write, two-read file. It adds:
- configurable width, depth and read-port count
- asynchronous clear
- write-to-read bypass
- a second write port for late (load/multi-cycle) writeback
- a pending-write scoreboard that lets the hazard unit stall on operands not yet written.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of registers (power of two, >=2); AW = clog2(DEPTH)
NREAD, 2, number of independent read ports (>=1)
ZERO_REG, 1, 1 = register 0 hardwired to zero (reads 0, writes dropped, never busy)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears registers, scoreboard and counter
we0  in  1  write enable, port 0 (ALU writeback)
waddr0  in  AW  write address, port 0
wdata0  in  WIDTH  write data, port 0
we1  in  1  write enable, port 1 (load/late writeback); also retires a pending write
waddr1  in  AW  write address, port 1
wdata1  in  WIDTH  write data, port 1
busy_set  in  1  marks busy_addr as pending (load issued)
busy_addr  in  AW  register to mark pending
raddr  in  NREAD*AW  packed read addresses; port i at bits [i*AW +: AW]
rdata  out  NREAD*WIDTH  packed read data; port i at bits [i*WIDTH +: WIDTH]
rbusy  out  NREAD  per-port "operand pending" flag
busy_count  out  AW+1  registered count of pending registers

Behaviour:
- Reset (async, any time, including mid-write): all registers = 0, all busy bits = 0, busy_count = 0. While reset is high, clock edges have no effect.
- Reset output values: rbusy = 0. rdata = 0 for every address, unless BYPASS forwards input data.
- Writes occur at the rising edge.
  - If we0 && we1 && waddr0 == waddr1, port 1 wins (wdata1 stored).
  - Writes to address 0 are dropped when ZERO_REG=1.
  - If DEPTH is not a power of two, addresses >= DEPTH are ignored.
- Reads: combinational, zero latency. rdata[i] = mem[raddr[i]].
  - With ZERO_REG=1 and raddr[i] == 0, rdata[i] = 0, overriding bypass.
- Bypass (BYPASS=1):
  - If we1 && waddr1 == raddr[i], rdata[i] = wdata1.
  - Else if we0 && waddr0 == raddr[i], rdata[i] = wdata0.
  - Else the stored value.
  - BYPASS=0: the stored (pre-edge) value only.
- Scoreboard: one busy bit per register, updated at the rising edge.
  - busy_set sets busy[busy_addr].
  - we1 clears busy[waddr1].
  - we0 never touches busy bits.
  - Same edge, same address, set and clear: set wins (new load issued behind retiring one).
  - busy_set on an already-busy register: stays busy, no count change.
  - we1 on a non-busy register: plain write, no count change.
  - ZERO_REG=1: busy_set to address 0 is ignored.
- rbusy[i] = busy[raddr[i]], combinational.
  - With BYPASS=1, rbusy[i] is forced 0 when we1 && waddr1 == raddr[i] in the same cycle (data is forwarded).
  - Always 0 for address 0 when ZERO_REG=1.
- busy_count update per edge:
  - +1 for each busy bit transitioning 0->1.
  - -1 for each busy bit transitioning 1->0.
  - Net change per edge is in {-1, 0, +1}.
  - Saturates neither way: at most DEPTH by construction, never negative.
  - busy_count equals the popcount of the busy bits after every edge.

Test Plan:
- Reset then read: preload r5=0xDEADBEEF, assert reset mid-cycle -> rdata for r5 = 0 immediately (async), busy_count = 0, rbusy = 0.
- Dual write conflict: we0=we1=1, waddr0=waddr1=7, wdata0=0x11, wdata1=0x22 -> after edge, read r7 = 0x22. Same cycle with BYPASS=1, rdata port reading r7 = 0x22 pre-edge.
- Zero register: write 0xFFFFFFFF to r0 on both ports, plus busy_set r0 -> read r0 = 0 on all ports, rbusy = 0, busy_count = 0.
- Scoreboard: busy_set r3 -> next cycle rbusy for raddr=3 = 1, busy_count = 1. Then we1 to r3 with wdata1=0x55 -> that cycle rbusy = 0, rdata = 0x55. After edge, busy_count = 0.
- Set/clear collision: r9 busy; same edge busy_set r9 and we1 r9 -> r9 still busy, busy_count unchanged at 1, r9 holds wdata1.
- Parameter sweep: WIDTH=16, DEPTH=8, NREAD=4, BYPASS=0 -> a write to r6 is not visible until after the edge. All 4 ports read independent addresses correctly. busy_count width = 4.
